// File: rtl/sd_cmd_sequencer_if.sv
// Bundle between the processor memory map, the command sequencer and the
// SD controller: request handshake, command frame/start, response and status.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface sd_cmd_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_index;
  logic [31:0] req_arg;
  logic [47:0] sd_cmd;
  logic        sd_start;
  logic        sd_resp_valid;
  logic [7:0]  sd_resp;
  logic        busy;
  logic        done;
  logic        timed_out;
  logic [7:0]  resp_out;

  modport slave (
    input  req_valid, req_index, req_arg, sd_resp_valid, sd_resp,
    output req_ready, sd_cmd, sd_start, busy, done, timed_out, resp_out
  );

  modport master (
    output req_valid, req_index, req_arg, sd_resp_valid, sd_resp,
    input  req_ready, sd_cmd, sd_start, busy, done, timed_out, resp_out
  );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// Single SD command sequencer: latches index/argument, builds the 48-bit
// command frame, holds sd_start for the whole response wait and reports the
// response byte or a timeout.
// Build option SD_CRC7_EN: when defined, a bit-serial CRC7 is computed over
// the frame (40 extra cycles); otherwise a constant CRC byte is chosen by index.
module sd_cmd_sequencer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input logic           clk,
  input logic           rst,
  sd_cmd_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef SD_CRC7_EN
    S_CRC,
`endif
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [15:0] cnt_q, cnt_d;
  logic        prev_q, prev_d;
  logic [47:0] sd_cmd_q, sd_cmd_d;
  logic        sd_start_q, sd_start_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        timed_out_q, timed_out_d;
  logic [7:0]  resp_out_q, resp_out_d;
  logic [7:0]  crc_byte;
  logic        accept;
  logic        resp_rise;

`ifdef SD_CRC7_EN
  logic [6:0]  crc_q, crc_d;
  logic [39:0] crc_msg;
  logic        crc_bit;

  // One LFSR step of x^7 + x^3 + 1, message bit entering MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign crc_msg = {2'b01, idx_q, arg_q};
  assign crc_bit = crc_msg[6'd39 - cnt_q[5:0]];
`endif

  assign accept    = (state_q == S_IDLE) && bus.req_valid && ready_q;
  assign resp_rise = bus.sd_resp_valid && !prev_q;

  // Next-state and registered-output computation for the command FSM.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    arg_d       = arg_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    sd_cmd_d    = sd_cmd_q;
    sd_start_d  = sd_start_q;
    done_d      = 1'b0;
    timed_out_d = timed_out_q;
    resp_out_d  = resp_out_q;
`ifdef SD_CRC7_EN
    crc_d       = crc_q;
    crc_byte    = {crc_q, 1'b1};
`else
    case (idx_q)
      6'd0:    crc_byte = 8'h95;
      6'd8:    crc_byte = 8'h87;
      default: crc_byte = 8'h01;
    endcase
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          idx_d       = bus.req_index;
          arg_d       = bus.req_arg;
          timed_out_d = 1'b0;
          cnt_d       = '0;
`ifdef SD_CRC7_EN
          crc_d       = '0;
          state_d     = S_CRC;
`else
          state_d     = S_ISSUE;
`endif
        end
      end
`ifdef SD_CRC7_EN
      S_CRC: begin
        crc_d = crc7_step(crc_q, crc_bit);
        cnt_d = cnt_q + 16'd1;
        if (cnt_q[5:0] == 6'd39) state_d = S_ISSUE;
      end
`endif
      S_ISSUE: begin
        sd_cmd_d   = {2'b01, idx_q, arg_q, crc_byte};
        sd_start_d = 1'b1;
        cnt_d      = '0;
        prev_d     = bus.sd_resp_valid;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        prev_d = bus.sd_resp_valid;
        cnt_d  = cnt_q + 16'd1;
        // A response edge on the final timeout cycle still counts as a response.
        if (resp_rise) begin
          resp_out_d = bus.sd_resp;
          state_d    = S_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          resp_out_d  = 8'hFF;
          timed_out_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        sd_start_d = 1'b0;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    // Ready follows the registered state, so it reappears one cycle after DONE.
    ready_d = (state_q == S_IDLE) && !accept;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      arg_q       <= '0;
      cnt_q       <= '0;
      prev_q      <= 1'b0;
      sd_cmd_q    <= '1;
      sd_start_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      timed_out_q <= 1'b0;
      resp_out_q  <= 8'hFF;
`ifdef SD_CRC7_EN
      crc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      arg_q       <= arg_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      sd_cmd_q    <= sd_cmd_d;
      sd_start_q  <= sd_start_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      timed_out_q <= timed_out_d;
      resp_out_q  <= resp_out_d;
`ifdef SD_CRC7_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.sd_cmd    = sd_cmd_q;
  assign bus.sd_start  = sd_start_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.timed_out = timed_out_q;
  assign bus.resp_out  = resp_out_q;

endmodule

// File: doc/sd_cmd_sequencer.md
# sd_cmd_sequencer

Sequences single SD commands for the memory-mapped SD interface. It takes a command index and argument from the memory map, builds the 48-bit SD command frame with CRC7, and drives the SD controller's command/start inputs. It then waits for the controller's response byte or a timeout and returns the status to the processor. It sits between `MemoryMap` and `SDController`, replacing direct processor writes of raw 48-bit frames.

## Interface
- `TIMEOUT`, default 1024: cycles spent in WAIT before the command is abandoned. Range 1..65535.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  command request from the memory map.
- `req_ready`  out  1  high only in IDLE; a request is accepted on `req_valid && req_ready`.
- `req_index`  in  6  SD command index.
- `req_arg`  in  32  SD command argument.
- `sd_cmd`  out  48  frame to `SDController`: {2'b01, index, arg, crc7, 1'b1}.
- `sd_start`  out  1  start level to `SDController`.
- `sd_resp_valid`  in  1  response-byte-present level from `SDController`.
- `sd_resp`  in  8  response byte from `SDController`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a command completes, by response or by timeout.
- `timed_out`  out  1  status of the last command: 1 = timed out.
- `resp_out`  out  8  captured response byte for the last command.

## Operation
- States: IDLE → CRC → ISSUE → WAIT → DONE → IDLE. CRC exists only when `SD_CRC7_EN` is defined.
- IDLE: on acceptance, latch `req_index`/`req_arg`, clear `timed_out`, clear the CRC register.
- CRC: bit-serial CRC7 with polynomial x^7+x^3+1, MSB first, computed over the 40 bits {2'b01, index, arg}. One bit per cycle, 40 cycles, then go to ISSUE.
- ISSUE: load `sd_cmd`, raise `sd_start`, clear the timeout counter, sample the current `sd_resp_valid` into the edge register, go to WAIT.
- WAIT: `sd_start` stays high and `sd_cmd` stays stable.
  - A rising edge of `sd_resp_valid` (0 in the previous cycle, 1 now) captures `sd_resp` into `resp_out` and moves to DONE.
  - A level that was already high on entry to WAIT is not a response.
  - If the counter reaches `TIMEOUT - 1` with no edge: `resp_out` ← 8'hFF, `timed_out` ← 1, move to DONE.
  - If an edge and the timeout occur in the same cycle, the response wins.
- DONE: `sd_start` ← 0, `done` = 1 for one cycle, then IDLE. `sd_cmd` holds its last value.
- `req_valid` while busy is ignored; the request is not queued.
- Reset (`rst` = 0 at a `clk` edge) takes priority in any state:
  - state ← IDLE.
  - `sd_start`, `done`, `busy`, `timed_out` ← 0.
  - `sd_cmd` ← 48'hFFFF_FFFF_FFFF (idle-high line).
  - `resp_out` ← 8'hFF.
  - `req_ready` ← 1.
  - Reset mid-command drops `sd_start` on that edge; no `done` pulse is produced.

## Timing
- Acceptance edge is T.
  - With CRC: CRC occupies T+1..T+40; `sd_cmd`/`sd_start` are valid after edge T+41.
  - Without CRC: valid after edge T+1.
- Response rising edge seen at edge R: `resp_out` valid and `done` high after edge R+1; `req_ready` high after edge R+2.
- Timeout: `done` is asserted `TIMEOUT` + 1 cycles after `sd_start` rises.
- `sd_start` is a level held for the whole of WAIT, because `SDController` samples it on the much slower SD clock. The minimum high time is one WAIT cycle.
- All outputs are registered.

## Configuration
- `SD_CRC7_EN` defined: the hardware CRC7 and CRC state are built, and any index/argument gets a correct CRC.
- `SD_CRC7_EN` undefined: no CRC logic. The CRC byte {crc7, 1} is a constant chosen by index:
  - 8'h95 for index 0.
  - 8'h87 for index 8.
  - 8'h01 for all others. This is valid only for SPI mode with CRC checking off.
- Issue latency drops from 41 to 1 cycle.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles with `req_valid` = 1. Required: `sd_cmd` = 48'hFFFF_FFFF_FFFF, `resp_out` = 8'hFF, `sd_start` = 0, `busy` = 0, `req_ready` = 1.
- CMD0: index 0, arg 0. Required: `sd_cmd` = 48'h40_0000_0000_95 in both builds. Pulse `sd_resp_valid` with `sd_resp` = 8'h01. Required: `resp_out` = 8'h01, `timed_out` = 0, one `done` pulse.
- CMD8: index 8, arg 32'h0000_01AA. Required: `sd_cmd` = 48'h48_0000_01AA_87. With `SD_CRC7_EN`, `sd_start` rises exactly 41 cycles after acceptance.
- Timeout: `TIMEOUT` = 16, no response. Required: `done` at `sd_start` rise + 17 cycles, `timed_out` = 1, `resp_out` = 8'hFF. A following request clears `timed_out` on acceptance.
- Stale level and collision:
  - `sd_resp_valid` held high before issue produces no capture until it falls and rises again.
  - A rising edge exactly on the timeout cycle yields `timed_out` = 0 with the response byte captured.
- Mid-command reset: assert `rst` = 0 during WAIT. Required: `sd_start` = 0 after that edge, no `done` pulse, and a new CMD0 is accepted afterwards and completes normally.
